word_byte_sched: RTL and testbench
==================================

# word_byte_sched

Sequencing controller for the 32-bit byte splitter datapath. It accepts one 32-bit word through a valid/ready handshake, then drives the four bytes out one at a time on a byte stream with its own valid/ready handshake. It optionally inserts idle gap cycles between bytes. It sits between a word producer (register file or bus side) and a byte-wide consumer (UART-style or display sink).

## Interface

Parameters:
- GAP, default 0: idle cycles inserted after each non-final byte transfer. Legal range is 0..15.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-low reset. It is sampled on the rising edge of clk, and the block is in reset while reset==0.
- in_valid, input, 1: producer has a word on in_data.
- in_ready, output, 1: block can accept a word. High only in IDLE.
- in_data, input, 32: word to split.
- out_valid, output, 1: out_data holds a valid byte.
- out_ready, input, 1: consumer accepts the byte.
- out_data, output, 8: current byte.
- out_idx, output, 2: byte lane of out_data. Lane 3 is bits [31:24] and lane 0 is bits [7:0].
- out_last, output, 1: current byte is the final byte of the word.
- busy, output, 1: a word is in flight (state is not IDLE).

## Operation

- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1.
  - GAP_WAIT: out_valid=0, gap counter running.
- IDLE → SEND when in_valid&&in_ready.
  - The word is latched into an internal 32-bit register.
  - The sequence counter (seq, 2 bits) is cleared to 0.
- SEND with out_valid&&out_ready (a byte transfer):
  - If seq==3: go to IDLE.
  - Else if GAP==0: seq+1 and stay in SEND.
  - Else: seq+1, load the gap counter with GAP, and go to GAP_WAIT.
- SEND without out_ready: hold. out_data, out_idx and out_last stay stable until the transfer happens.
- GAP_WAIT: decrement the gap counter each cycle. When it reaches 1, go to SEND.
- Lane mapping: out_idx = 3−seq (MSB first by default). out_data = word[8*out_idx +: 8].
- out_last = (seq==3) in SEND. It is 0 in all other states.
- in_data and in_valid are ignored outside IDLE. No new word is accepted on the same edge as the final byte transfer.
- seq does not wrap. The exit to IDLE at seq==3 is the only path out of the last byte.

## Timing

- Reset values:
  - in_ready=1, out_valid=0, out_data=8'h00, out_idx=0, out_last=0, busy=0.
  - State is IDLE; seq, gap counter and word register are cleared.
- Latency: if a word is accepted at edge k, the first byte is valid in the cycle after edge k.
- All outputs come from registered state, so there is no combinational path from in_valid or out_ready to any output.
- Throughput with GAP=0 and out_ready held at 1: 4 bytes per 5 cycles (one IDLE acceptance cycle per word).
- Throughput in general: one word per 5+3·GAP cycles.
- Reset asserted mid-word (in SEND or GAP_WAIT): the word is discarded. The reset values above hold from the next edge. No partial byte is replayed after reset is released.

## Configuration

- WORD_BYTE_SCHED_LSB_FIRST_EN:
  - Undefined: bytes go out MSB first, out_idx sequence 3,2,1,0.
  - Defined: bytes go out LSB first, out_idx = seq, sequence 0,1,2,3.
  - Handshake, out_last and timing are identical in both builds.

## Structure

- Package word_byte_sched_pkg holds:
  - BYTE_W=8, NBYTES=4, WORD_W=32;
  - the state encoding IDLE=2'd0, SEND=2'd1, GAP_WAIT=2'd2;
  - the gap counter width (4).
- Sub-module byte_lane_sel: combinational 32→8 selector driven by word and lane index. It is instantiated once, and its output is registered into out_data.
- The FSM, seq counter and gap counter live in word_byte_sched.

## Test plan

- Reset: hold reset=0 for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, busy=0, out_data=8'h00, and no word is accepted.
- Basic word, GAP=0, out_ready=1: in_data=32'h000041C3 → bytes 00,00,41,C3 with out_idx 3,2,1,0, out_last only on C3, and in_ready high again on the 5th cycle.
- Backpressure: in_data=32'hDEADBEEF, out_ready low for 3 cycles on byte AD → out_data stays AD with out_idx=2 throughout, then BE and EF follow.
- GAP=2: in_data=32'h12345678 → out_valid pattern 1,0,0,1,0,0,1,0,0,1, with bytes 12,34,56,78.
- Reset mid-word: assert reset after byte 34 of 32'h12345678 → next cycle out_valid=0 and in_ready=1. The next word 32'hA5A5A5A5 emits A5 ×4 cleanly.
- LSB-first build (WORD_BYTE_SCHED_LSB_FIRST_EN defined): 32'h000041C3 → C3,41,00,00 with out_idx 0,1,2,3, out_last on the final 00.

Source files
------------

// File: rtl/word_byte_sched_pkg.sv
// Shared definitions for the word-to-byte sequencer: widths, FSM state
// encoding, gap counter width and the sequence-to-lane mapping.
// Build option: WORD_BYTE_SCHED_LSB_FIRST_EN selects LSB-first lane order.
package word_byte_sched_pkg;

    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;
    localparam int WORD_W = 32;
    localparam int IDX_W  = 2;
    localparam int GAP_CW = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        GAP_WAIT = 2'd2
    } state_t;

    // Map the transfer sequence number (0 = first byte out) to a byte lane.
    function automatic logic [IDX_W-1:0] lane_of(input logic [IDX_W-1:0] seq);
`ifdef WORD_BYTE_SCHED_LSB_FIRST_EN
        return seq;
`else
        return IDX_W'(NBYTES - 1) - seq;
`endif
    endfunction

endpackage

// File: rtl/word_byte_sched_lane_sel.sv
// Combinational 32-to-8 lane selector. Lane 0 is word[7:0], lane 3 is
// word[31:24]. The caller registers the result.
module byte_lane_sel
    import word_byte_sched_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [BYTE_W-1:0] lane_byte
);

    logic [BYTE_W-1:0] lanes [NBYTES];

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign lanes[gi] = word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    assign lane_byte = lanes[idx];

endmodule

// File: rtl/word_byte_sched.sv
// Word-to-byte sequencer: accepts one 32-bit word on a valid/ready input,
// then emits its four bytes on a valid/ready byte stream, optionally with
// GAP idle cycles after every non-final byte. All outputs are registered.
// Build option: WORD_BYTE_SCHED_LSB_FIRST_EN emits lane 0 first instead of lane 3.
module word_byte_sched
    import word_byte_sched_pkg::*;
#(
    parameter int GAP = 0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'(GAP);
    localparam logic [IDX_W-1:0]  SEQ_LAST = IDX_W'(NBYTES - 1);

    state_t              state_reg;
    logic [IDX_W-1:0]    seq_reg;
    logic [GAP_CW-1:0]   gap_cnt_reg;
    logic [WORD_W-1:0]   word_reg;

    logic                in_ready_reg;
    logic                out_valid_reg;
    logic [BYTE_W-1:0]   out_data_reg;
    logic [IDX_W-1:0]    out_idx_reg;
    logic                out_last_reg;
    logic                busy_reg;

    // Lane selector inputs: the byte that becomes current at the next edge.
    // In IDLE that is the first byte of the incoming word; otherwise it is
    // the byte after the current one in the latched word.
    logic [WORD_W-1:0]   sel_word;
    logic [IDX_W-1:0]    sel_seq;
    logic [IDX_W-1:0]    sel_idx;
    logic [BYTE_W-1:0]   sel_byte;

    // Pick the word and sequence number that feed the lane selector.
    always_comb begin
        sel_word = word_reg;
        sel_seq  = seq_reg + IDX_W'(1);
        if (state_reg == IDLE) begin
            sel_word = in_data;
            sel_seq  = '0;
        end
        sel_idx = lane_of(sel_seq);
    end

    byte_lane_sel u_lane_sel (
        .word      (sel_word),
        .idx       (sel_idx),
        .lane_byte (sel_byte)
    );

    // Handshake FSM with sequence and gap counters; every output is a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            seq_reg       <= '0;
            gap_cnt_reg   <= '0;
            word_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg     <= SEND;
                        word_reg      <= in_data;
                        seq_reg       <= '0;
                        in_ready_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= sel_byte;
                        out_idx_reg   <= sel_idx;
                        out_last_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end

                SEND: begin
                    if (out_ready) begin
                        if (seq_reg == SEQ_LAST) begin
                            // Final byte accepted; the next word can only
                            // be taken from the following cycle onward.
                            state_reg     <= IDLE;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                        end else begin
                            seq_reg      <= sel_seq;
                            out_data_reg <= sel_byte;
                            out_idx_reg  <= sel_idx;
                            if (GAP == 0) begin
                                out_last_reg <= (sel_seq == SEQ_LAST);
                            end else begin
                                // Next byte is preloaded but hidden until
                                // the gap expires.
                                state_reg     <= GAP_WAIT;
                                gap_cnt_reg   <= GAP_LOAD;
                                out_valid_reg <= 1'b0;
                                out_last_reg  <= 1'b0;
                            end
                        end
                    end
                end

                GAP_WAIT: begin
                    gap_cnt_reg <= gap_cnt_reg - GAP_CW'(1);
                    if (gap_cnt_reg <= GAP_CW'(1)) begin
                        state_reg     <= SEND;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (seq_reg == SEQ_LAST);
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_word_byte_sched.sv
// Directed bench for word_byte_sched: one instance with GAP=0 and one with
// GAP=2 share clock and reset. Expected byte order follows
// WORD_BYTE_SCHED_LSB_FIRST_EN when the bench is built with it.
module tb_word_byte_sched;

    logic        clk = 1'b0;
    logic        reset;

    logic        iv0, ir0, ov0, or0, ol0, bz0;
    logic [31:0] id0;
    logic [7:0]  od0;
    logic [1:0]  oi0;

    logic        iv2, ir2, ov2, or2, ol2, bz2;
    logic [31:0] id2;
    logic [7:0]  od2;
    logic [1:0]  oi2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_byte_sched #(.GAP(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .out_idx(oi0), .out_last(ol0), .busy(bz0)
    );

    word_byte_sched #(.GAP(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2),
        .out_idx(oi2), .out_last(ol2), .busy(bz2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lane carrying the k-th byte sent.
    function automatic int lane(input int k);
`ifdef WORD_BYTE_SCHED_LSB_FIRST_EN
        return k;
`else
        return 3 - k;
`endif
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
        int i;
        i = lane(k);
        return w[8*i +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;

        // Reset held two cycles with in_valid asserted: nothing accepted.
        reset = 1'b0;
        iv0 = 1'b1; id0 = 32'hFFFF_FFFF; or0 = 1'b1;
        iv2 = 1'b1; id2 = 32'hFFFF_FFFF; or2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(ir0), 32'(1));
        chk("rst_out_valid", 32'(ov0), 32'(0));
        chk("rst_busy",      32'(bz0), 32'(0));
        chk("rst_out_data",  32'(od0), 32'h00);
        chk("rst_out_idx",   32'(oi0), 32'(0));
        chk("rst_out_last",  32'(ol0), 32'(0));
        chk("rst_g2_ready",  32'(ir2), 32'(1));
        chk("rst_g2_valid",  32'(ov2), 32'(0));
        iv0 = 1'b0; iv2 = 1'b0;
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("idle_after_release_ready", 32'(ir0), 32'(1));
        chk("idle_after_release_valid", 32'(ov0), 32'(0));

        // Basic word, GAP=0, consumer always ready.
        w = 32'h0000_41C3;
        iv0 = 1'b1; id0 = w;
        step();
        iv0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            $display("basic byte %0d: data=%h idx=%0d last=%0b", k, od0, oi0, ol0);
            chk("basic_valid", 32'(ov0), 32'(1));
            chk("basic_data",  32'(od0), 32'(byte_at(w, k)));
            chk("basic_idx",   32'(oi0), 32'(lane(k)));
            chk("basic_last",  32'(ol0), 32'(k == 3));
            chk("basic_busy",  32'(bz0), 32'(1));
            chk("basic_ready", 32'(ir0), 32'(0));
            step();
        end
        @(negedge clk);
        chk("basic_end_ready", 32'(ir0), 32'(1));
        chk("basic_end_valid", 32'(ov0), 32'(0));
        chk("basic_end_busy",  32'(bz0), 32'(0));

        // Backpressure on the second byte for three cycles.
        w = 32'hDEAD_BEEF;
        iv0 = 1'b1; id0 = w;
        step();
        iv0 = 1'b0;
        @(negedge clk);
        chk("bp_b0_data", 32'(od0), 32'(byte_at(w, 0)));
        step();
        or0 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            $display("stall %0d: data=%h idx=%0d valid=%0b", s, od0, oi0, ov0);
            chk("bp_hold_valid", 32'(ov0), 32'(1));
            chk("bp_hold_data",  32'(od0), 32'(byte_at(w, 1)));
            chk("bp_hold_idx",   32'(oi0), 32'(lane(1)));
            chk("bp_hold_last",  32'(ol0), 32'(0));
            step();
        end
        or0 = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            $display("bp byte %0d: data=%h idx=%0d last=%0b", k, od0, oi0, ol0);
            chk("bp_data", 32'(od0), 32'(byte_at(w, k)));
            chk("bp_idx",  32'(oi0), 32'(lane(k)));
            chk("bp_last", 32'(ol0), 32'(k == 3));
            step();
        end
        @(negedge clk);
        chk("bp_end_ready", 32'(ir0), 32'(1));

        // GAP=2 instance: valid pattern 1,0,0 repeating, ending in 1.
        w = 32'h1234_5678;
        iv2 = 1'b1; id2 = w;
        step();
        iv2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            $display("gap cycle %0d: valid=%0b data=%h idx=%0d last=%0b", c, ov2, od2, oi2, ol2);
            chk("gap_valid", 32'(ov2), 32'(c % 3 == 0));
            chk("gap_busy",  32'(bz2), 32'(1));
            if (c % 3 == 0) begin
                chk("gap_data", 32'(od2), 32'(byte_at(w, c / 3)));
                chk("gap_idx",  32'(oi2), 32'(lane(c / 3)));
                chk("gap_last", 32'(ol2), 32'(c == 9));
            end else begin
                chk("gap_last_low", 32'(ol2), 32'(0));
            end
            step();
        end
        @(negedge clk);
        chk("gap_end_ready", 32'(ir2), 32'(1));
        chk("gap_end_busy",  32'(bz2), 32'(0));

        // Reset during the gap that follows the second byte.
        iv2 = 1'b1; id2 = w;
        step();
        iv2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_valid", 32'(ov2), 32'(c % 3 == 0));
            if (c % 3 == 0) chk("mid_data", 32'(od2), 32'(byte_at(w, c / 3)));
            step();
        end
        reset = 1'b0;
        step();
        @(negedge clk);
        $display("after mid-word reset: valid=%0b ready=%0b busy=%0b", ov2, ir2, bz2);
        chk("midrst_valid", 32'(ov2), 32'(0));
        chk("midrst_ready", 32'(ir2), 32'(1));
        chk("midrst_busy",  32'(bz2), 32'(0));
        chk("midrst_data",  32'(od2), 32'h00);
        chk("midrst_last",  32'(ol2), 32'(0));
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_no_replay", 32'(ov2), 32'(0));

        w = 32'hA5A5_A5A5;
        iv2 = 1'b1; id2 = w;
        step();
        iv2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("a5_valid", 32'(ov2), 32'(c % 3 == 0));
            if (c % 3 == 0) begin
                $display("a5 byte %0d: data=%h idx=%0d last=%0b", c / 3, od2, oi2, ol2);
                chk("a5_data", 32'(od2), 32'hA5);
                chk("a5_idx",  32'(oi2), 32'(lane(c / 3)));
                chk("a5_last", 32'(ol2), 32'(c == 9));
            end
            step();
        end
        @(negedge clk);
        chk("a5_end_ready", 32'(ir2), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
